// File: rtl/duck_sprite_pkg.sv
// Shared types and constants for the duck sprite renderer.
package duck_sprite_pkg;

    localparam int unsigned COLOR_W   = 4;
    localparam int unsigned PAL_IDX_W = 4;
    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;

    typedef logic [COLOR_W-1:0]   color_t;
    typedef logic [PAL_IDX_W-1:0] pal_idx_t;

    // Palette index that lets the background show through.
    localparam pal_idx_t TRANSPARENT_IDX = pal_idx_t'(0);

    typedef struct packed {
        color_t red;
        color_t green;
        color_t blue;
    } rgb_t;

endpackage

// File: rtl/duck_sprite_palette.sv
// Combinational palette: 4-bit sprite index to 12-bit RGB.
module duck_sprite_palette
    import duck_sprite_pkg::*;
(
    input  logic [PAL_IDX_W-1:0] idx,
    output logic [COLOR_W-1:0]   red_c,
    output logic [COLOR_W-1:0]   green_c,
    output logic [COLOR_W-1:0]   blue_c
);

    rgb_t color;

    // Duck colours in the low entries, grey ramp for the rest.
    always_comb begin
        color = '{red: idx, green: idx, blue: idx};
        case (idx)
            4'd1:    color = '{red: 4'hF, green: 4'hF, blue: 4'h0};
            4'd2:    color = '{red: 4'hF, green: 4'h8, blue: 4'h0};
            4'd3:    color = '{red: 4'h0, green: 4'h0, blue: 4'h0};
            4'd4:    color = '{red: 4'hF, green: 4'hF, blue: 4'hF};
            4'd5:    color = '{red: 4'h8, green: 4'h8, blue: 4'h0};
            4'd6:    color = '{red: 4'h0, green: 4'h8, blue: 4'hF};
            4'd7:    color = '{red: 4'h4, green: 4'h4, blue: 4'h4};
            default: ;
        endcase
    end

    assign red_c   = color.red;
    assign green_c = color.green;
    assign blue_c  = color.blue;

endmodule

// File: rtl/duck_sprite_renderer.sv
// Animated, scalable sprite renderer over a VGA scan with a 3-cycle
// DrawX-to-RGB pipeline and a synchronous sprite ROM.
// Optional macro DUCK_SPRITE_MIRROR_EN adds a horizontal mirror input.
module duck_sprite_renderer
    import duck_sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W     = 64,
    parameter int unsigned SPRITE_H     = 64,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned FRAMES       = 4,
    parameter int unsigned FRAME_PERIOD = 8,
    localparam int unsigned ADDR_W      = $clog2(FRAMES * SPRITE_W * SPRITE_H)
)(
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_valid,
`ifdef DUCK_SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    output logic              pos_ack,
    input  logic              anim_en,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [3:0]        rom_q,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pixel_on
);

    localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam int unsigned COL_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int unsigned FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned TICK_W   = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [10:0] SPAN_X   = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] SPAN_Y   = 11'(SPRITE_H << SCALE_LOG2);

    logic [9:0]         px;
    logic [9:0]         py;
    logic [FRAME_W-1:0] frame;
    logic [TICK_W-1:0]  tick;
`ifdef DUCK_SPRITE_MIRROR_EN
    logic               mirror_q;
`endif

    logic [10:0]        x_rel;
    logic [10:0]        y_rel;
    logic               hit_c;
    logic [COL_W-1:0]   col_c;
    logic [COL_W-1:0]   col_sel_c;
    logic [ROW_W-1:0]   row_c;
    logic [ADDR_W-1:0]  addr_c;

    logic               hit_s1;
    logic               blank_s1;
    rgb_t               bg_s1;
    logic               hit_s2;
    logic               blank_s2;
    rgb_t               bg_s2;

    logic [3:0]         pal_red_c;
    logic [3:0]         pal_green_c;
    logic [3:0]         pal_blue_c;

    // Position is only taken at frame boundaries so a frame is drawn at one place.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            px      <= '0;
            py      <= '0;
            pos_ack <= 1'b0;
`ifdef DUCK_SPRITE_MIRROR_EN
            mirror_q <= 1'b0;
`endif
        end else begin
            pos_ack <= frame_tick && pos_valid;
            if (frame_tick && pos_valid) begin
                px <= pos_x;
                py <= pos_y;
`ifdef DUCK_SPRITE_MIRROR_EN
                mirror_q <= mirror;
`endif
            end
        end
    end

    // Animation step every FRAME_PERIOD frame ticks; frozen while anim_en is low.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            tick  <= '0;
            frame <= '0;
        end else if (frame_tick && anim_en) begin
            if (tick == TICK_W'(FRAME_PERIOD - 1)) begin
                tick  <= '0;
                frame <= (frame == FRAME_W'(FRAMES - 1)) ? '0 : frame + FRAME_W'(1);
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

    // Hit test in 11 bits so a sprite near the right/bottom edge never wraps to 0.
    always_comb begin
        x_rel     = {1'b0, DrawX} - {1'b0, px};
        y_rel     = {1'b0, DrawY} - {1'b0, py};
        hit_c     = ({1'b0, DrawX} >= {1'b0, px}) && ({1'b0, DrawX} < ({1'b0, px} + SPAN_X)) &&
                    ({1'b0, DrawY} >= {1'b0, py}) && ({1'b0, DrawY} < ({1'b0, py} + SPAN_Y));
        col_c     = COL_W'(x_rel >> SCALE_LOG2);
        row_c     = ROW_W'(y_rel >> SCALE_LOG2);
`ifdef DUCK_SPRITE_MIRROR_EN
        col_sel_c = mirror_q ? (COL_W'(SPRITE_W - 1) - col_c) : col_c;
`else
        col_sel_c = col_c;
`endif
        addr_c    = '0;
        if (hit_c) begin
            addr_c = ADDR_W'(32'(frame) * FRAME_SZ + 32'(row_c) * SPRITE_W + 32'(col_sel_c));
        end
    end

    // Stage 1 issues the ROM read; stage 2 waits out the ROM latency.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            hit_s1      <= 1'b0;
            blank_s1    <= 1'b0;
            bg_s1       <= '0;
            hit_s2      <= 1'b0;
            blank_s2    <= 1'b0;
            bg_s2       <= '0;
        end else begin
            rom_address <= addr_c;
            hit_s1      <= hit_c;
            blank_s1    <= blank;
            bg_s1       <= '{red: bg_red, green: bg_green, blue: bg_blue};
            hit_s2      <= hit_s1;
            blank_s2    <= blank_s1;
            bg_s2       <= bg_s1;
        end
    end

    duck_sprite_palette u_palette (
        .idx     (rom_q),
        .red_c   (pal_red_c),
        .green_c (pal_green_c),
        .blue_c  (pal_blue_c)
    );

    // Stage 3 composites sprite over background, blanking outside active video.
    always_ff @(posedge vga_clk) begin
        if (reset || !blank_s2) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            pixel_on <= 1'b0;
        end else if (!hit_s2 || (rom_q == TRANSPARENT_IDX)) begin
            red      <= bg_s2.red;
            green    <= bg_s2.green;
            blue     <= bg_s2.blue;
            pixel_on <= 1'b0;
        end else begin
            red      <= pal_red_c;
            green    <= pal_green_c;
            blue     <= pal_blue_c;
            pixel_on <= 1'b1;
        end
    end

endmodule

// File: tb/tb_duck_sprite_renderer.sv
// Scoreboard bench for duck_sprite_renderer (default build and optional
// DUCK_SPRITE_MIRROR_EN build).
`timescale 1ns/1ps
module tb_duck_sprite_renderer;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        pos_valid = 1'b0;
    logic        anim_en = 1'b0;
    logic [3:0]  bg_red = '0;
    logic [3:0]  bg_green = '0;
    logic [3:0]  bg_blue = '0;
`ifdef DUCK_SPRITE_MIRROR_EN
    logic        mirror = 1'b0;
`endif

    logic        pos_ack, pos_ack_s;
    logic [13:0] rom_address, rom_address_s;
    logic [3:0]  rom_q = '0;
    logic [3:0]  rom_q_s = '0;
    logic [3:0]  red, green, blue, red_s, green_s, blue_s;
    logic        pixel_on, pixel_on_s;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;
    int pid = 0;
    int m_px = 0, m_py = 0, m_frame = 0;
    bit m_mirror = 1'b0;
    bit rom_zero = 1'b0;

    typedef struct { int due; int id; logic [11:0] rgb; logic on; } exp_t;
    typedef struct { int due; int id; logic [13:0] a; } aexp_t;
    exp_t  pq[$];
    aexp_t aq[$];

    always #5 vga_clk = ~vga_clk;

    duck_sprite_renderer dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
`ifdef DUCK_SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .pos_ack(pos_ack), .anim_en(anim_en), .bg_red(bg_red), .bg_green(bg_green),
        .bg_blue(bg_blue), .rom_address(rom_address), .rom_q(rom_q), .red(red),
        .green(green), .blue(blue), .pixel_on(pixel_on)
    );

    duck_sprite_renderer #(.SCALE_LOG2(1)) dut_s (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
`ifdef DUCK_SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .pos_ack(pos_ack_s), .anim_en(anim_en), .bg_red(bg_red), .bg_green(bg_green),
        .bg_blue(bg_blue), .rom_address(rom_address_s), .rom_q(rom_q_s), .red(red_s),
        .green(green_s), .blue(blue_s), .pixel_on(pixel_on_s)
    );

    function automatic logic [3:0] rom_fn(input int a);
        return 4'((a % 15) + 1);
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] i);
        case (i)
            4'd1:    return 12'hFF0;
            4'd2:    return 12'hF80;
            4'd3:    return 12'h000;
            4'd4:    return 12'hFFF;
            4'd5:    return 12'h880;
            4'd6:    return 12'h08F;
            4'd7:    return 12'h444;
            default: return {i, i, i};
        endcase
    endfunction

    // Synchronous ROM models: data one cycle after the address.
    always @(posedge vga_clk) begin
        rom_q   <= rom_zero ? 4'd0 : rom_fn(int'(rom_address));
        rom_q_s <= rom_fn(int'(rom_address_s));
    end

    always @(posedge vga_clk) ecnt <= ecnt + 1;

    // Scoreboard: compare address and pixel output when each comes due.
    always @(negedge vga_clk) begin
        aexp_t ae;
        exp_t  e;
        while (aq.size() > 0 && aq[0].due <= ecnt) begin
            ae = aq.pop_front();
            checks++;
            if (rom_address !== ae.a) begin
                failures++;
                $display("FAIL rom_address id=%0d got=%0d exp=%0d", ae.id, rom_address, ae.a);
            end
        end
        while (pq.size() > 0 && pq[0].due <= ecnt) begin
            e = pq.pop_front();
            checks++;
            if ({red, green, blue} !== e.rgb || pixel_on !== e.on) begin
                failures++;
                $display("FAIL pixel id=%0d got rgb=%h on=%b exp rgb=%h on=%b",
                         e.id, {red, green, blue}, pixel_on, e.rgb, e.on);
            end
        end
    end

    task automatic drive_pix(input int x, input int y, input logic bl, input logic [11:0] bg);
        exp_t        e;
        aexp_t       ae;
        logic        hit;
        int          col, row, a;
        logic [3:0]  q;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        {bg_red, bg_green, bg_blue} = bg;
        hit = (x >= m_px) && (x < m_px + 64) && (y >= m_py) && (y < m_py + 64);
        col = x - m_px;
        row = y - m_py;
        if (m_mirror) col = 63 - col;
        a = hit ? (m_frame * 4096 + row * 64 + col) : 0;
        q = rom_zero ? 4'd0 : rom_fn(a);
        e.due = ecnt + 3;
        e.id  = pid;
        if (!bl) begin
            e.rgb = 12'h000; e.on = 1'b0;
        end else if (!hit || q == 4'd0) begin
            e.rgb = bg; e.on = 1'b0;
        end else begin
            e.rgb = pal(q); e.on = 1'b1;
        end
        ae.due = ecnt + 1;
        ae.id  = pid;
        ae.a   = 14'(a);
        pq.push_back(e);
        aq.push_back(ae);
        pid++;
        @(posedge vga_clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pq.size() > 0 || aq.size() > 0) && n < 10) begin
            @(posedge vga_clk); #1;
            n++;
        end
        if (pq.size() > 0 || aq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", pq.size() + aq.size());
            pq.delete();
            aq.delete();
        end
    endtask

    task automatic load_pos(input int x, input int y);
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = 1'b1; frame_tick = 1'b1;
        @(posedge vga_clk); #1;
        checks++;
        if (pos_ack !== 1'b1 || pos_ack_s !== 1'b1) begin
            failures++;
            $display("FAIL pos_ack_load got=%b/%b exp=1", pos_ack, pos_ack_s);
        end
        pos_valid = 1'b0; frame_tick = 1'b0;
        m_px = x; m_py = y;
`ifdef DUCK_SPRITE_MIRROR_EN
        m_mirror = mirror;
`endif
        @(posedge vga_clk); #1;
        checks++;
        if (pos_ack !== 1'b0) begin
            failures++;
            $display("FAIL pos_ack_pulse got=%b exp=0", pos_ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b1; pos_valid = 1'b1; anim_en = 1'b1;
        pos_x = 10'd200; pos_y = 10'd200; blank = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        checks++;
        if ({red, green, blue, pixel_on} !== 13'd0) begin
            failures++;
            $display("FAIL reset_out got=%h exp=0", {red, green, blue, pixel_on});
        end
        checks++;
        if (rom_address !== 14'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d exp=0", rom_address);
        end
        checks++;
        if (pos_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got=%b exp=0", pos_ack);
        end
        reset = 1'b0; frame_tick = 1'b0; pos_valid = 1'b0; anim_en = 1'b0;
        m_px = 0; m_py = 0; m_frame = 0;
    endtask

    task automatic test_scale();
        drive_pix(3, 5, 1'b1, 12'h5A5);
        checks++;
        if (rom_address_s !== 14'd129) begin
            failures++;
            $display("FAIL scale_addr got=%0d exp=129", rom_address_s);
        end
        drive_pix(127, 5, 1'b1, 12'h5A5);
        checks++;
        if (rom_address_s !== 14'd191) begin
            failures++;
            $display("FAIL scale_addr_edge got=%0d exp=191", rom_address_s);
        end
        drive_pix(128, 5, 1'b1, 12'h5A5);
        checks++;
        if (rom_address_s !== 14'd0) begin
            failures++;
            $display("FAIL scale_addr_miss got=%0d exp=0", rom_address_s);
        end
        checks++;
        if ({red_s, green_s, blue_s, pixel_on_s} !== {12'hAAA, 1'b1}) begin
            failures++;
            $display("FAIL scale_rgb got=%h exp=%h", {red_s, green_s, blue_s, pixel_on_s}, {12'hAAA, 1'b1});
        end
        drain();
    endtask

    task automatic test_position_hold();
        int acks;
        acks = 0;
        DrawX = 10'd10; DrawY = 10'd0; blank = 1'b1;
        pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
        repeat (100) begin
            @(posedge vga_clk); #1;
            if (pos_ack !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL hold_ack got=%0d exp=0", acks);
        end
        checks++;
        if (rom_address !== 14'd10) begin
            failures++;
            $display("FAIL hold_pos got=%0d exp=10", rom_address);
        end
        load_pos(100, 50);
    endtask

    task automatic test_pixels();
        int          xs[9]  = '{100, 99, 101, 163, 164, 100, 100, 120, 10};
        int          ys[9]  = '{50, 50, 51, 50, 50, 113, 114, 60, 0};
        logic        bls[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic [11:0] bgs[9] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF,
                                12'h321, 12'h654, 12'h987, 12'h111};
        for (int i = 0; i < 9; i++) drive_pix(xs[i], ys[i], bls[i], bgs[i]);
        drain();
    endtask

    task automatic test_anim();
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; anim_en = 1'b1;
        for (int p = 1; p <= 41; p++) begin
            frame_tick = 1'b1; @(posedge vga_clk); #1;
            frame_tick = 1'b0; @(posedge vga_clk); #1;
            checks++;
            if (rom_address !== 14'(((p / 8) % 4) * 4096)) begin
                failures++;
                $display("FAIL anim pulse=%0d got=%0d exp=%0d", p, rom_address, ((p / 8) % 4) * 4096);
            end
        end
        anim_en = 1'b0;
        for (int p = 1; p <= 20; p++) begin
            frame_tick = 1'b1; @(posedge vga_clk); #1;
            frame_tick = 1'b0; @(posedge vga_clk); #1;
            checks++;
            if (rom_address !== 14'd4096) begin
                failures++;
                $display("FAIL anim_freeze pulse=%0d got=%0d exp=4096", p, rom_address);
            end
        end
        anim_en = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            frame_tick = 1'b1; @(posedge vga_clk); #1;
            frame_tick = 1'b0; @(posedge vga_clk); #1;
            checks++;
            if (rom_address !== ((p == 7) ? 14'd8192 : 14'd4096)) begin
                failures++;
                $display("FAIL anim_resume pulse=%0d got=%0d exp=%0d", p, rom_address,
                         (p == 7) ? 8192 : 4096);
            end
        end
        anim_en = 1'b0;
        m_frame = 2;
    endtask

    task automatic test_edge();
        load_pos(1000, 470);
        drive_pix(1023, 470, 1'b1, 12'h246);
        drive_pix(0, 470, 1'b1, 12'h357);
        drive_pix(1023, 533, 1'b1, 12'h468);
        drive_pix(1000, 534, 1'b1, 12'h579);
        drive_pix(1000, 470, 1'b1, 12'h68A);
        drain();
        rom_zero = 1'b1;
        drive_pix(1023, 470, 1'b1, 12'h9BD);
        drive_pix(1010, 480, 1'b1, 12'hACE);
        drive_pix(1023, 470, 1'b0, 12'hBDF);
        drain();
        rom_zero = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (3) drive_pix(1001, 471, 1'b1, 12'h135);
        drain();
        checks++;
        if (pixel_on !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_on got=%b exp=1", pixel_on);
        end
        reset = 1'b1; frame_tick = 1'b1; pos_valid = 1'b1; anim_en = 1'b1;
        pos_x = 10'd300; pos_y = 10'd300;
        @(posedge vga_clk); #1;
        checks++;
        if ({red, green, blue, pixel_on, pos_ack} !== 14'd0 || rom_address !== 14'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h addr=%0d exp=0", {red, green, blue, pixel_on, pos_ack}, rom_address);
        end
        reset = 1'b0; frame_tick = 1'b0; pos_valid = 1'b0; anim_en = 1'b0;
        m_px = 0; m_py = 0; m_frame = 0; m_mirror = 1'b0;
        drive_pix(5, 5, 1'b1, 12'h222);
        checks++;
        if ({red, green, blue, pixel_on} !== 13'd0) begin
            failures++;
            $display("FAIL post_reset_1 got=%h exp=0", {red, green, blue, pixel_on});
        end
        drive_pix(6, 5, 1'b1, 12'h333);
        checks++;
        if ({red, green, blue, pixel_on} !== 13'd0) begin
            failures++;
            $display("FAIL post_reset_2 got=%h exp=0", {red, green, blue, pixel_on});
        end
        drive_pix(70, 5, 1'b1, 12'h444);
        drain();
    endtask

`ifdef DUCK_SPRITE_MIRROR_EN
    task automatic test_mirror();
        mirror = 1'b1;
        load_pos(0, 0);
        drive_pix(0, 0, 1'b1, 12'h777);
        drive_pix(63, 1, 1'b1, 12'h777);
        drain();
        mirror = 1'b0;
        load_pos(0, 0);
        drive_pix(0, 0, 1'b1, 12'h777);
        drain();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_scale();
        test_position_hold();
        test_pixels();
        test_anim();
        test_edge();
        test_reset_mid();
`ifdef DUCK_SPRITE_MIRROR_EN
        test_mirror();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
